// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared constants and FSM state type for the round-robin decoder arbiter.
package rr_decoder_arbiter_pkg;
   localparam int N_REQ        = 16;
   localparam int IDX_W        = 4;
   localparam int MAX_HOLD_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;
endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Requester-side bus of the arbiter: request vector in, grant status and FSM debug state out.
interface rr_decoder_arbiter_if;
   import rr_decoder_arbiter_pkg::*;

   // Handshake: a requester holds req[i] high for as long as it wants the resource;
   // it owns it while grant[i] is high, and dropping req[i] is the release.
   logic [N_REQ-1:0] req;
   logic [IDX_W-1:0] binary_out;
   logic             enable_out;
   logic [N_REQ-1:0] grant;
   logic             busy;
   logic             revoked;
   state_e           state_dbg;

   modport slave (
      input  req,
      output binary_out, enable_out, grant, busy, revoked, state_dbg
   );

   modport master (
      output req,
      input  binary_out, enable_out, grant, busy, revoked, state_dbg
   );
endinterface

// File: rtl/rr_decoder_arbiter_decoder.sv
// Binary-to-one-hot decoder with enable; all-zero output when enable is low.
module rr_decoder_arbiter_decoder #(
   parameter int IDX_W = 4,
   parameter int N_OUT = 16
) (
   input  logic [IDX_W-1:0] binary_in,
   input  logic             enable,
   output logic [N_OUT-1:0] decoder_out
);
   always_comb begin
      decoder_out = '0;
      if (enable) decoder_out[binary_in] = 1'b1;
   end
endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter over 16 requesters with registered index/valid and decoded grant.
// Optional forced revoke after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_decoder_arbiter
   import rr_decoder_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rr_decoder_arbiter_if.slave   bus
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
      $error("MAX_HOLD must be in 2..255");
   end

   state_e           state, state_next;
   logic [IDX_W-1:0] binary_q;
   logic [IDX_W-1:0] last_ptr;
   logic [IDX_W-1:0] winner;
   logic             enable_q;
   logic             holder_req;
   logic             timeout_hit;

   // Search starts just above last_ptr and wraps; last_ptr itself is visited last.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] pick;
      logic             found;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = last + IDX_W'(i);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign winner     = rr_pick(bus.req, last_ptr);
   assign holder_req = bus.req[binary_q];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_cnt;
   logic       revoked_q;

   assign timeout_hit = (hold_cnt == 8'(MAX_HOLD - 1));

   // A release on the timeout edge wins, so revoked only fires while the holder still requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= 8'd0;
         revoked_q <= 1'b0;
      end else begin
         hold_cnt  <= (state == GRANT) ? hold_cnt + 8'd1 : 8'd0;
         revoked_q <= (state == GRANT) && holder_req && timeout_hit;
      end
   end

   assign bus.revoked = revoked_q;
`else
   assign timeout_hit = 1'b0;
   assign bus.revoked = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Leaving GRANT always passes through IDLE, which enforces the gap between grants.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (|bus.req) state_next = GRANT;
         GRANT:   if (!holder_req || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         binary_q <= '0;
         last_ptr <= '1;
         enable_q <= 1'b0;
      end else begin
         enable_q <= (state_next == GRANT);
         if (state == IDLE && |bus.req) begin
            binary_q <= winner;
            last_ptr <= winner;
         end
      end
   end

   always_comb begin
      bus.busy       = (state != IDLE);
      bus.state_dbg  = state;
      bus.binary_out = binary_q;
      bus.enable_out = enable_q;
   end

   rr_decoder_arbiter_decoder #(
      .IDX_W (IDX_W),
      .N_OUT (N_REQ)
   ) u_decoder (
      .binary_in   (binary_q),
      .enable      (enable_q),
      .decoder_out (bus.grant)
   );

endmodule

// File: doc/rr_decoder_arbiter.md
RR_DECODER_ARBITER -- requirements
Module: rr_decoder_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles before forced revoke; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  16  request vector; bit i high = requester i wants the shared resource.
REQ-005 binary_out  output  4  registered index of the current grant holder.
REQ-006 enable_out  output  1  registered grant-valid; high only in GRANT.
REQ-007 grant  output  16  one-hot grant = decode of binary_out gated by enable_out; all-zero when enable_out low.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 revoked  output  1  one-cycle pulse on the cycle a grant is force-revoked by timeout.

Function
REQ-010 FSM states: IDLE and GRANT only.
REQ-011 IDLE, req == 0: stay in IDLE; outputs hold reset values, except binary_out, which keeps the last granted index.
REQ-012 IDLE, req != 0 at a rising edge: select the winner and go to GRANT; binary_out = winner and enable_out = 1, visible after that edge (1-cycle latency).
REQ-013 Winner selection: the first set bit of req, searching upward from last_ptr+1 and wrapping 15 -> 0; last_ptr itself is searched last.
REQ-014 On each grant, last_ptr = winner.
REQ-015 GRANT, req[binary_out] == 1: hold grant; binary_out is stable and req on other bits is ignored.
REQ-016 GRANT, req[binary_out] == 0 at a rising edge: go to IDLE; enable_out = 0 after that edge.
REQ-017 Minimum one IDLE cycle between consecutive grants; no back-to-back grants.
REQ-018 hold_cnt (8 bits): cleared on entry to GRANT; increments each GRANT cycle.
REQ-019 Simultaneous release and timeout on the same edge: treat as a release; revoked stays low.
REQ-020 Single requester on bit i: it is re-granted after each mandatory IDLE cycle.
REQ-021 Wrap-around: last_ptr = 15 with req = 16'h0001 grants index 0.
REQ-022 grant shall be combinational from registered signals only, with no path from req.

Reset
REQ-023 rst_n low, asynchronously: state = IDLE, binary_out = 0, enable_out = 0, grant = 0, busy = 0, revoked = 0, hold_cnt = 0, last_ptr = 15.
REQ-024 Reset asserted mid-GRANT drops enable_out and grant in the same cycle, without waiting for clk.
REQ-025 After rst_n deasserts, the first grant goes to the lowest set req bit.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: in GRANT, when hold_cnt == MAX_HOLD-1 and req[binary_out] is still high at an edge, go to IDLE, drop enable_out and pulse revoked for one cycle; last_ptr is unchanged, so the next search skips the revoked requester.
REQ-027 Macro ARB_TIMEOUT_EN undefined: no timeout; grant is held until release; revoked is tied to 0; hold_cnt and its logic are absent.

Structure
REQ-028 Shared package contains: N_REQ = 16, IDX_W = 4, the FSM state typedef (IDLE, GRANT) and the MAX_HOLD default.
REQ-029 One sub-module: the team's existing decoder (binary_in, enable, decoder_out), instantiated to produce grant from binary_out and enable_out.
REQ-030 The round-robin search is a function inside rr_decoder_arbiter, not a separate module.

Verification
REQ-031 Reset, then req = 16'h0000 for 5 cycles -> enable_out = 0, grant = 0, busy = 0 throughout.
REQ-032 After reset, req = 16'h8001 -> grant = 16'h0001 one cycle later; drop req[0] -> IDLE one cycle; grant = 16'h8000 next.
REQ-033 req = 16'hFFFF, each holder releases after 2 cycles -> grant order 0, 1, 2, ..., 15, 0, with one IDLE cycle between grants.
REQ-034 ARB_TIMEOUT_EN, MAX_HOLD = 4, req = 16'h0024 held high -> grant index 2 for 4 cycles, revoked pulse, IDLE, then index 5 for 4 cycles, then index 2.
REQ-035 rst_n pulsed low mid-grant of index 7 -> grant = 0 immediately; after release, req = 16'h0080 -> index 7 granted again.
REQ-036 Without ARB_TIMEOUT_EN, req = 16'h0002 held for 300 cycles -> grant stays 16'h0002 and revoked stays 0.
